// File: rtl/mcu51_fetch_pkg.sv
// Shared definitions for the MCU51 fetch path: FSM states, length codes and
// the MCS-51 opcode length table used by both fetch and decode.
package mcu51_fetch_pkg;

  typedef enum logic [1:0] {
    S_OP   = 2'd0,
    S_B1   = 2'd1,
    S_B2   = 2'd2,
    S_HOLD = 2'd3
  } fetch_state_t;

  localparam logic [1:0] LEN_1 = 2'd1;
  localparam logic [1:0] LEN_2 = 2'd2;
  localparam logic [1:0] LEN_3 = 2'd3;

  // Every opcode ending in 1 is AJMP/ACALL (2 bytes); the rest are listed
  // explicitly, with anything not named being a single-byte instruction.
  function automatic logic [1:0] insn_len(input logic [7:0] opcode);
    logic [1:0] len;
    len = LEN_1;
    if (opcode[3:0] == 4'h1) begin
      len = LEN_2;
    end else begin
      case (opcode)
        8'h02, 8'h10, 8'h12, 8'h20, 8'h30, 8'h43, 8'h53, 8'h63,
        8'h75, 8'h85, 8'h90, 8'hD5,
        8'hB4, 8'hB5, 8'hB6, 8'hB7, 8'hB8, 8'hB9, 8'hBA, 8'hBB,
        8'hBC, 8'hBD, 8'hBE, 8'hBF:
          len = LEN_3;
        8'h05, 8'h15, 8'h24, 8'h25, 8'h34, 8'h35,
        8'h40, 8'h42, 8'h44, 8'h45, 8'h50, 8'h52, 8'h54, 8'h55,
        8'h60, 8'h62, 8'h64, 8'h65, 8'h70, 8'h72, 8'h74, 8'h76, 8'h77,
        8'h78, 8'h79, 8'h7A, 8'h7B, 8'h7C, 8'h7D, 8'h7E, 8'h7F,
        8'h80, 8'h82, 8'h86, 8'h87,
        8'h88, 8'h89, 8'h8A, 8'h8B, 8'h8C, 8'h8D, 8'h8E, 8'h8F,
        8'h92, 8'h94, 8'h95, 8'hA0, 8'hA2, 8'hA6, 8'hA7,
        8'hA8, 8'hA9, 8'hAA, 8'hAB, 8'hAC, 8'hAD, 8'hAE, 8'hAF,
        8'hB0, 8'hB2, 8'hC0, 8'hC2, 8'hC5, 8'hD0, 8'hD2,
        8'hD8, 8'hD9, 8'hDA, 8'hDB, 8'hDC, 8'hDD, 8'hDE, 8'hDF,
        8'hE5, 8'hF5:
          len = LEN_2;
        default:
          len = LEN_1;
      endcase
    end
    return len;
  endfunction

endpackage

// File: rtl/insn_len_dec.sv
// Combinational opcode-to-length decoder; thin wrapper so the decoder stage
// can reuse the same table as fetch.
module insn_len_dec
  import mcu51_fetch_pkg::*;
(
  input  logic [7:0] opcode,
  output logic [1:0] len
);

  assign len = insn_len(opcode);

endmodule

// File: rtl/prog_fetch.sv
// MCU51 instruction fetch: reads 1-3 bytes per instruction from program ROM
// and hands a bundle to decode. Define IFETCH_CS_GATE_EN to deassert mem_cs_n while idle.
module prog_fetch
  import mcu51_fetch_pkg::*;
#(
  parameter int ADDRWIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  output logic                 mem_cs_n,
  output logic [ADDRWIDTH-1:0] mem_addr,
  input  logic [7:0]           mem_dout,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [ADDRWIDTH-1:0] out_pc,
  output logic [7:0]           out_op,
  output logic [7:0]           out_b1,
  output logic [7:0]           out_b2,
  output logic [1:0]           out_len,
  input  logic                 redir_valid,
  input  logic [ADDRWIDTH-1:0] redir_addr
);

`ifdef IFETCH_CS_GATE_EN
  localparam logic CS_N_RESET = 1'b1;
`else
  localparam logic CS_N_RESET = 1'b0;
`endif

  fetch_state_t         state, state_next;
  logic [ADDRWIDTH-1:0] pc, pc_next;
  logic [ADDRWIDTH-1:0] mem_addr_next;
  logic [ADDRWIDTH-1:0] out_pc_next;
  logic [7:0]           op_next, b1_next, b2_next;
  logic [1:0]           len_next;
  logic [1:0]           dec_len;
  logic                 valid_next;
  logic                 cs_n_next;

  insn_len_dec u_len_dec (
    .opcode (mem_dout),
    .len    (dec_len)
  );

  // Next-state and datapath. The address for the following instruction is
  // staged on entry to S_HOLD so the opcode read is ready right after accept.
  always_comb begin
    state_next    = state;
    pc_next       = pc;
    mem_addr_next = mem_addr;
    valid_next    = out_valid;
    out_pc_next   = out_pc;
    op_next       = out_op;
    b1_next       = out_b1;
    b2_next       = out_b2;
    len_next      = out_len;

    if (redir_valid) begin
      state_next    = S_OP;
      pc_next       = redir_addr;
      mem_addr_next = redir_addr;
      valid_next    = 1'b0;
    end else begin
      case (state)
        S_OP: begin
          out_pc_next = pc;
          op_next     = mem_dout;
          b1_next     = 8'h00;
          b2_next     = 8'h00;
          len_next    = dec_len;
          if (dec_len != LEN_1) begin
            mem_addr_next = pc + ADDRWIDTH'(1);
            state_next    = S_B1;
          end else begin
            mem_addr_next = pc + ADDRWIDTH'(dec_len);
            valid_next    = 1'b1;
            state_next    = S_HOLD;
          end
        end
        S_B1: begin
          b1_next = mem_dout;
          if (out_len == LEN_3) begin
            mem_addr_next = pc + ADDRWIDTH'(2);
            state_next    = S_B2;
          end else begin
            mem_addr_next = pc + ADDRWIDTH'(out_len);
            valid_next    = 1'b1;
            state_next    = S_HOLD;
          end
        end
        S_B2: begin
          b2_next       = mem_dout;
          mem_addr_next = pc + ADDRWIDTH'(out_len);
          valid_next    = 1'b1;
          state_next    = S_HOLD;
        end
        S_HOLD: begin
          if (out_valid && out_ready) begin
            pc_next    = pc + ADDRWIDTH'(out_len);
            valid_next = 1'b0;
            state_next = S_OP;
          end
        end
        default: begin
          state_next = S_OP;
        end
      endcase
    end

`ifdef IFETCH_CS_GATE_EN
    cs_n_next = (state_next == S_HOLD);
`else
    cs_n_next = 1'b0;
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_OP;
      pc        <= '0;
      mem_addr  <= '0;
      mem_cs_n  <= CS_N_RESET;
      out_valid <= 1'b0;
      out_pc    <= '0;
      out_op    <= 8'h00;
      out_b1    <= 8'h00;
      out_b2    <= 8'h00;
      out_len   <= LEN_1;
    end else begin
      state     <= state_next;
      pc        <= pc_next;
      mem_addr  <= mem_addr_next;
      mem_cs_n  <= cs_n_next;
      out_valid <= valid_next;
      out_pc    <= out_pc_next;
      out_op    <= op_next;
      out_b1    <= b1_next;
      out_b2    <= b2_next;
      out_len   <= len_next;
    end
  end

endmodule
